// File: rtl/wb_pkg.sv
// Shared types for the pipelined writeback stage.
//   wdSrc_e    : register-file result select (ALU / immU / load / pc+4)
//   loadSize_e : load access width (encoding 3 is handled as a word)
//   wbState_e  : writeback slot occupancy FSM
//   isTaken()  : branch/jump resolution from the execute-stage flags
package wb_pkg;

  typedef enum logic [1:0] {
    WD_ALU  = 2'd0,
    WD_IMMU = 2'd1,
    WD_LOAD = 2'd2,
    WD_PC4  = 2'd3
  } wdSrc_e;

  typedef enum logic [1:0] {
    LS_BYTE = 2'd0,
    LS_HALF = 2'd1,
    LS_WORD = 2'd2
  } loadSize_e;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FULL     = 2'd1,
    ST_WAIT_MEM = 2'd2
  } wbState_e;

  // Branch taken when the ALU zero flag matches the condition polarity.
  function automatic logic isTaken(input logic jump, input logic branch,
                                   input logic aluZero, input logic condZero);
    return jump | (branch & ~(aluZero ^ condZero));
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Load-data extraction: selects the addressed byte/half lane of a naturally
// aligned 32-bit memory word and sign- or zero-extends it to XLEN.
//   memRdata     in  XLEN  raw memory read data (low 32 bits hold the word)
//   byteOff      in  2     address bits [1:0]
//   loadSize     in  2     byte / half / word (3 treated as word)
//   loadUnsigned in  1     zero-extend instead of sign-extend
//   loadData     out XLEN  aligned, extended result
module wb_load_align
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] memRdata,
  input  logic [1:0]      byteOff,
  input  logic [1:0]      loadSize,
  input  logic            loadUnsigned,
  output logic [XLEN-1:0] loadData
);

  logic [31:0]     word;
  logic [7:0]      laneByte;
  logic [15:0]     laneHalf;
  logic [XLEN-1:0] wordExt;

  assign word = memRdata[31:0];

  always_comb begin
    laneByte = '0;
    case (byteOff)
      2'd0:    laneByte = word[7:0];
      2'd1:    laneByte = word[15:8];
      2'd2:    laneByte = word[23:16];
      default: laneByte = word[31:24];
    endcase
    // Halfword lane chosen by bit 1 only; bit 0 is ignored for halves.
    laneHalf = byteOff[1] ? word[31:16] : word[15:0];
  end

  generate
    if (XLEN > 32) begin : gWide
      assign wordExt = {{(XLEN-32){~loadUnsigned & word[31]}}, word};
    end else begin : gNarrow
      assign wordExt = word;
    end
  endgenerate

  always_comb begin
    loadData = '0;
    case (loadSize_e'(loadSize))
      LS_BYTE: loadData = {{(XLEN-8){~loadUnsigned & laneByte[7]}}, laneByte};
      LS_HALF: loadData = {{(XLEN-16){~loadUnsigned & laneHalf[15]}}, laneHalf};
      default: loadData = wordExt;
    endcase
  end

endmodule

// File: rtl/wb_stage_p.sv
// Writeback stage: one registered pipeline slot with valid/ready handshake,
// result select, load extraction, branch/jump resolution and RF write control.
// Loads wait in WAIT_MEM for mem_rvalid (optionally bounded by MEM_TIMEOUT).
//   clk, rst                 clock, async active-high reset
//   in_valid / in_ready      upstream handshake
//   in_*                     decoded instruction fields captured into the slot
//   mem_rvalid / mem_rdata   load response
//   flush                    kill occupant, block capture
//   rf_we / rf_rd / rf_wdata register-file write port
//   redirect_valid / _pc     PC redirect
//   wb_valid                 instruction retired this cycle
//   mem_err                  load dropped on timeout this cycle
module wb_stage_p
  import wb_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned RF_AW       = 5,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_reg_write,
  input  logic [1:0]       in_wd_src,
  input  logic [RF_AW-1:0] in_rd,
  input  logic [XLEN-1:0]  in_imm_u,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_pc_branch,
  input  logic [XLEN-1:0]  in_pc_plus4,
  input  logic             in_alu_zero,
  input  logic             in_cond_zero,
  input  logic             in_branch,
  input  logic             in_jump,
  input  logic [1:0]       in_load_size,
  input  logic             in_load_unsigned,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             flush,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_rd,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             wb_valid,
  output logic             mem_err
);

  localparam bit          TO_EN    = (MEM_TIMEOUT > 0);
  localparam int unsigned CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int unsigned CNT_LIM  = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LIM);

  wbState_e         state, stateNext;
  logic [CNT_W-1:0] waitCnt;

  logic             slotRegWrite;
  wdSrc_e           slotWdSrc;
  logic [RF_AW-1:0] slotRd;
  logic [XLEN-1:0]  slotImmU, slotAlu, slotPcBranch, slotPcPlus4;
  logic             slotAluZero, slotCondZero, slotBranch, slotJump;
  logic [1:0]       slotLoadSize;
  logic             slotLoadUnsigned;

  logic             retire, timeoutHit, capture;
  logic [XLEN-1:0]  loadData;

  assign retire = ~flush & ((state == ST_FULL) | ((state == ST_WAIT_MEM) & mem_rvalid));
  assign timeoutHit = TO_EN & ~flush & (state == ST_WAIT_MEM) & ~mem_rvalid &
                      (waitCnt == CNT_LAST);
  assign in_ready = ~rst & ((state == ST_EMPTY) | retire);
  assign capture  = in_valid & in_ready & ~flush;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    if (flush)                      stateNext = ST_EMPTY;
    else if (capture)               stateNext = (wdSrc_e'(in_wd_src) == WD_LOAD) ? ST_WAIT_MEM : ST_FULL;
    else if (retire || timeoutHit)  stateNext = ST_EMPTY;
  end

  // Slot registers and load-wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slotRegWrite     <= 1'b0;
      slotWdSrc        <= WD_ALU;
      slotRd           <= '0;
      slotImmU         <= '0;
      slotAlu          <= '0;
      slotPcBranch     <= '0;
      slotPcPlus4      <= '0;
      slotAluZero      <= 1'b0;
      slotCondZero     <= 1'b0;
      slotBranch       <= 1'b0;
      slotJump         <= 1'b0;
      slotLoadSize     <= '0;
      slotLoadUnsigned <= 1'b0;
    end else if (capture) begin
      slotRegWrite     <= in_reg_write;
      slotWdSrc        <= wdSrc_e'(in_wd_src);
      slotRd           <= in_rd;
      slotImmU         <= in_imm_u;
      slotAlu          <= in_alu_result;
      slotPcBranch     <= in_pc_branch;
      slotPcPlus4      <= in_pc_plus4;
      slotAluZero      <= in_alu_zero;
      slotCondZero     <= in_cond_zero;
      slotBranch       <= in_branch;
      slotJump         <= in_jump;
      slotLoadSize     <= in_load_size;
      slotLoadUnsigned <= in_load_unsigned;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      waitCnt <= '0;
    else if (flush || capture || timeoutHit)      waitCnt <= '0;
    else if (TO_EN && (state == ST_WAIT_MEM) && !mem_rvalid)
                                                  waitCnt <= waitCnt + CNT_W'(1);
  end

  wb_load_align #(.XLEN(XLEN)) uAlign (
    .memRdata     (mem_rdata),
    .byteOff      (slotAlu[1:0]),
    .loadSize     (slotLoadSize),
    .loadUnsigned (slotLoadUnsigned),
    .loadData     (loadData)
  );

  // Output logic: everything is held at zero unless the occupant retires.
  always_comb begin
    wb_valid       = 1'b0;
    rf_we          = 1'b0;
    rf_rd          = '0;
    rf_wdata       = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_err        = timeoutHit;
    if (retire) begin
      wb_valid       = 1'b1;
      rf_we          = slotRegWrite & (slotRd != '0);
      rf_rd          = slotRd;
      redirect_valid = isTaken(slotJump, slotBranch, slotAluZero, slotCondZero);
      redirect_pc    = slotPcBranch;
      case (slotWdSrc)
        WD_ALU:  rf_wdata = slotAlu;
        WD_IMMU: rf_wdata = slotImmU;
        WD_LOAD: rf_wdata = loadData;
        default: rf_wdata = slotPcPlus4;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage_p.sv
module tb_wb_stage_p;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RF_AW = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_reg_write;
  logic [1:0]       in_wd_src;
  logic [RF_AW-1:0] in_rd;
  logic [XLEN-1:0]  in_imm_u, in_alu_result, in_pc_branch, in_pc_plus4;
  logic             in_alu_zero, in_cond_zero, in_branch, in_jump;
  logic [1:0]       in_load_size;
  logic             in_load_unsigned;
  logic             mem_rvalid;
  logic [XLEN-1:0]  mem_rdata;
  logic             flush;
  logic             rf_we;
  logic [RF_AW-1:0] rf_rd;
  logic [XLEN-1:0]  rf_wdata;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             wb_valid, mem_err;

  always #5 clk = ~clk;

  wb_stage_p #(.XLEN(XLEN), .RF_AW(RF_AW), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write(in_reg_write), .in_wd_src(in_wd_src), .in_rd(in_rd),
    .in_imm_u(in_imm_u), .in_alu_result(in_alu_result),
    .in_pc_branch(in_pc_branch), .in_pc_plus4(in_pc_plus4),
    .in_alu_zero(in_alu_zero), .in_cond_zero(in_cond_zero),
    .in_branch(in_branch), .in_jump(in_jump),
    .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .flush(flush),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .wb_valid(wb_valid), .mem_err(mem_err)
  );

  typedef struct {
    logic        memErr;
    logic        wbValid;
    logic        rfWe;
    logic [4:0]  rfRd;
    logic [31:0] rfWdata;
    logic        redirValid;
    logic [31:0] redirPc;
  } exp_t;

  exp_t expQ[$];
  exp_t expE;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic memErr, input logic wb, input logic we,
                         input logic [4:0] rd, input logic [31:0] wd,
                         input logic rv, input logic [31:0] rp);
    exp_t e;
    e.memErr = memErr; e.wbValid = wb; e.rfWe = we; e.rfRd = rd;
    e.rfWdata = wd; e.redirValid = rv; e.redirPc = rp;
    expQ.push_back(e);
  endtask

  // Monitor: any visible writeback activity is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (wb_valid || mem_err || rf_we || redirect_valid) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got wb_valid=%0b mem_err=%0b rf_we=%0b redirect_valid=%0b expected no activity",
                   wb_valid, mem_err, rf_we, redirect_valid);
        end else begin
          expE = expQ.pop_front();
          check("sb_wb_valid", wb_valid, expE.wbValid);
          check("sb_mem_err", mem_err, expE.memErr);
          check("sb_rf_we", rf_we, expE.rfWe);
          check("sb_redirect_valid", redirect_valid, expE.redirValid);
          if (expE.wbValid) begin
            check("sb_rf_rd", rf_rd, expE.rfRd);
            check("sb_rf_wdata", rf_wdata, expE.rfWdata);
          end
          if (expE.redirValid) check("sb_redirect_pc", redirect_pc, expE.redirPc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setOp(input logic rw, input logic [1:0] src, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] imm,
                       input logic [31:0] pcb, input logic [31:0] pc4,
                       input logic az, input logic cz, input logic br, input logic jp,
                       input logic [1:0] ls, input logic lu);
    in_reg_write = rw; in_wd_src = src; in_rd = rd; in_alu_result = alu;
    in_imm_u = imm; in_pc_branch = pcb; in_pc_plus4 = pc4;
    in_alu_zero = az; in_cond_zero = cz; in_branch = br; in_jump = jp;
    in_load_size = ls; in_load_unsigned = lu;
  endtask

  // Present the current fields for one accepted cycle.
  task automatic issue();
    int unsigned n;
    n = 0;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: got in_ready=0 for 20 cycles expected 1");
    end
    tick();
    in_valid = 1'b0;
  endtask

  logic [31:0] ldAddr[6], ldData[6], ldExp[6];
  logic [1:0]  ldSize[6];
  logic        ldUns[6];

  initial begin
    ldAddr[0] = 32'h0000_0000; ldData[0] = 32'hDEAD_BEEF; ldSize[0] = 2'd2; ldUns[0] = 1'b0; ldExp[0] = 32'hDEAD_BEEF;
    ldAddr[1] = 32'h0000_0010; ldData[1] = 32'h0000_8001; ldSize[1] = 2'd1; ldUns[1] = 1'b0; ldExp[1] = 32'hFFFF_8001;
    ldAddr[2] = 32'h0000_0021; ldData[2] = 32'h0000_AB00; ldSize[2] = 2'd0; ldUns[2] = 1'b1; ldExp[2] = 32'h0000_00AB;
    ldAddr[3] = 32'h0000_0030; ldData[3] = 32'h0000_007F; ldSize[3] = 2'd0; ldUns[3] = 1'b0; ldExp[3] = 32'h0000_007F;
    ldAddr[4] = 32'h0000_0040; ldData[4] = 32'h1234_5678; ldSize[4] = 2'd3; ldUns[4] = 1'b0; ldExp[4] = 32'h1234_5678;
    ldAddr[5] = 32'h0000_0052; ldData[5] = 32'h7FFF_0000; ldSize[5] = 2'd1; ldUns[5] = 1'b0; ldExp[5] = 32'h0000_7FFF;

    in_valid = 1'b0;
    setOp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_rvalid = 1'b0; mem_rdata = '0; flush = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_redirect_valid", redirect_valid, 0);
    check("rst_mem_err", mem_err, 0);
    rst = 1'b0;
    #1;
    check("rst_release_in_ready", in_ready, 1);

    // ALU writes, rd=0 retires without writing
    setOp(1, 0, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    pushExp(0, 1, 1, 5, 32'h1234, 0, 0); issue();
    setOp(1, 0, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    pushExp(0, 1, 0, 0, 32'h55, 0, 0); issue();
    // lui
    setOp(1, 1, 3, 32'h77, 32'hABCD_E000, 0, 0, 0, 0, 0, 0, 0, 0);
    pushExp(0, 1, 1, 3, 32'hABCD_E000, 0, 0); issue();
    // beq taken, beq not taken, bne-style taken, jal
    setOp(0, 0, 0, 0, 0, 32'h100, 32'h104, 1, 1, 1, 0, 0, 0);
    pushExp(0, 1, 0, 0, 0, 1, 32'h100); issue();
    setOp(0, 0, 0, 0, 0, 32'h140, 32'h144, 1, 0, 1, 0, 0, 0);
    pushExp(0, 1, 0, 0, 0, 0, 0); issue();
    setOp(0, 0, 0, 0, 0, 32'h180, 32'h184, 0, 0, 1, 0, 0, 0);
    pushExp(0, 1, 0, 0, 0, 1, 32'h180); issue();
    setOp(1, 3, 1, 32'h300, 0, 32'h300, 32'h204, 0, 0, 0, 1, 0, 0);
    pushExp(0, 1, 1, 1, 32'h204, 1, 32'h300); issue();

    // lb offset 3 after two wait cycles
    setOp(1, 2, 7, 32'h1003, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
    pushExp(0, 1, 1, 7, 32'hFFFF_FF80, 0, 0); issue();
    check("lb_wait1_in_ready", in_ready, 0);
    tick();
    check("lb_wait2_in_ready", in_ready, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0000;
    #1;
    check("lb_rvalid_in_ready", in_ready, 1);
    tick();
    mem_rvalid = 1'b0;

    // lhu offset 2, zero-wait
    setOp(1, 2, 8, 32'h2002, 0, 0, 0, 0, 0, 0, 0, 2'd1, 1);
    pushExp(0, 1, 1, 8, 32'h0000_80FF, 0, 0); issue();
    mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0000;
    tick();
    mem_rvalid = 1'b0;

    for (int unsigned i = 0; i < 6; i++) begin
      setOp(1, 2, 5'(9 + i), ldAddr[i], 0, 0, 0, 0, 0, 0, 0, ldSize[i], ldUns[i]);
      pushExp(0, 1, 1, 5'(9 + i), ldExp[i], 0, 0); issue();
      mem_rvalid = 1'b1; mem_rdata = ldData[i];
      tick();
      mem_rvalid = 1'b0;
    end

    // Load timeout: error in 4th wait cycle, then late rvalid ignored
    setOp(1, 2, 10, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 2'd2, 0);
    issue();
    pushExp(1, 0, 0, 0, 0, 0, 0);
    check("to_wait1_in_ready", in_ready, 0);
    tick(); tick();
    check("to_wait3_mem_err", mem_err, 0);
    tick();
    check("to_wait4_mem_err", mem_err, 1);
    check("to_wait4_rf_we", rf_we, 0);
    check("to_wait4_wb_valid", wb_valid, 0);
    tick();
    check("to_after_in_ready", in_ready, 1);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #1;
    check("to_late_wb_valid", wb_valid, 0);
    check("to_late_rf_we", rf_we, 0);
    tick();
    mem_rvalid = 1'b0;

    // Flush beats mem_rvalid and blocks capture
    setOp(1, 2, 11, 32'h4000, 0, 0, 0, 0, 0, 0, 0, 2'd2, 0);
    issue();
    setOp(1, 0, 13, 32'h999, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b1; flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    #1;
    check("flush_wb_valid", wb_valid, 0);
    check("flush_rf_we", rf_we, 0);
    check("flush_rf_wdata", rf_wdata, 0);
    check("flush_redirect_valid", redirect_valid, 0);
    check("flush_mem_err", mem_err, 0);
    tick();
    flush = 1'b0; mem_rvalid = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_after_in_ready", in_ready, 1);
    check("flush_after_wb_valid", wb_valid, 0);

    // Back-to-back ALU stream
    for (int unsigned i = 0; i < 6; i++) begin
      setOp(1, 0, 5'(i + 1), 32'h1000 + 32'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0);
      pushExp(0, 1, 1, 5'(i + 1), 32'h1000 + 32'(i), 0, 0);
      in_valid = 1'b1;
      #1;
      check("stream_in_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    tick();

    // Reset while waiting for load data
    setOp(1, 2, 12, 32'h5000, 0, 0, 0, 0, 0, 0, 0, 2'd2, 0);
    issue();
    tick();
    rst = 1'b1;
    #1;
    check("rstw_wb_valid", wb_valid, 0);
    check("rstw_rf_we", rf_we, 0);
    check("rstw_rf_wdata", rf_wdata, 0);
    check("rstw_mem_err", mem_err, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    check("rstw_rvalid_wb_valid", wb_valid, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rstw_release_in_ready", in_ready, 1);
    check("rstw_late_wb_valid", wb_valid, 0);
    tick();
    mem_rvalid = 1'b0;

    repeat (3) tick();
    check("queue_drained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_stage_p.md
# wb_stage_p

Parametrised writeback stage for the pipelined schoolRISCV core: a registered pipeline slot with valid/ready handshake, a 4-way result select, load-data extraction, branch/jump resolution and register-file write control. Sits between the execute/memory stage and the register file / PC mux. Unlike the fixed single-cycle writeback, it stalls on outstanding loads, supports flush, and is configurable in data width, register count and memory timeout.

## Interface
- XLEN, 32: datapath width; 32 or 64.
- RF_AW, 5: register-file address width.
- MEM_TIMEOUT, 16: max cycles waiting for load data; 0 disables timeout.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream slot holds an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_reg_write  in  1  instruction writes rd.
- in_wd_src  in  2  result select: 0 ALU, 1 immU, 2 load, 3 pc+4.
- in_rd  in  RF_AW  destination register.
- in_imm_u, in_alu_result, in_pc_branch, in_pc_plus4  in  XLEN each.
- in_alu_zero, in_cond_zero, in_branch, in_jump  in  1 each.
- in_load_size  in  2  0 byte, 1 half, 2 word (3 treated as word).
- in_load_unsigned  in  1  zero-extend load.
- mem_rvalid  in  1  load data valid this cycle.
- mem_rdata  in  XLEN  load data, naturally aligned word.
- flush  in  1  kill occupant, block capture.
- rf_we  out  1, rf_rd  out  RF_AW, rf_wdata  out  XLEN  register-file write port.
- redirect_valid  out  1, redirect_pc  out  XLEN  PC redirect.
- wb_valid  out  1  instruction retired this cycle.
- mem_err  out  1  load timed out this cycle.

## Operation
- FSM: EMPTY, FULL, WAIT_MEM. Reset -> EMPTY, counter 0, slot registers 0.
- Capture on in_valid & in_ready & ~flush: all in_* into slot; next state FULL (non-load) or WAIT_MEM (wd_src=2).
- in_ready = (state==EMPTY) | retire. Back-to-back capture on retire cycle allowed.
- retire = ~flush & ((state==FULL) | (state==WAIT_MEM & mem_rvalid)).
- On retire with no capture -> EMPTY; with capture -> FULL/WAIT_MEM per new occupant.
- Outputs combinational from slot (and mem_rdata), valid only when retire:
  - wb_valid = retire; rf_we = retire & reg_write & (rd != 0); rf_rd = slot rd.
  - rf_wdata: ALU / immU / extracted load / pc+4 per wd_src.
  - taken = jump | (branch & ~(alu_zero ^ cond_zero)); redirect_valid = retire & taken; redirect_pc = pc_branch.
- Load extraction: byte offset = alu_result[1:0] (half uses bit 1); shift lane down; sign- or zero-extend byte/half to XLEN; word sign-extends to XLEN when XLEN=64 unless unsigned.
- Timeout (MEM_TIMEOUT>0): counter increments each WAIT_MEM cycle without mem_rvalid, cleared on entry. When counter == MEM_TIMEOUT-1 and no mem_rvalid: mem_err=1 that cycle, occupant dropped (no write, no redirect, no wb_valid), state -> EMPTY (or captured next).
- flush: occupant suppressed same cycle (all outputs 0), no capture, next state EMPTY, counter cleared. Flush beats mem_rvalid and timeout.
- Reset mid-WAIT_MEM: immediate EMPTY; late mem_rvalid in EMPTY ignored.

## Timing
- Latency: capture edge -> outputs valid next cycle (non-load); load retires in first cycle with mem_rvalid.
- Throughput 1 instruction/cycle without loads or with zero-wait memory.
- All outputs 0 during and after reset; in_ready = 1 after reset release.
- No combinational path from in_* to outputs; in_ready depends combinationally on mem_rvalid and flush.

## Structure
- Package wb_pkg: wd_src enum (WD_ALU, WD_IMMU, WD_LOAD, WD_PC4), load size enum, FSM state enum.
- Sub-module wb_load_align: pure combinational lane select + extend (XLEN param).
- Top holds slot registers, FSM, timeout counter, output muxes.

## Test plan
- ALU op, rd=5, alu_result=0x1234 -> next cycle rf_we=1, rf_rd=5, rf_wdata=0x1234, wb_valid=1; rd=0 gives rf_we=0, wb_valid=1.
- lb unsigned=0, offset 3, mem_rdata=0x80FF_0000 after 2 wait cycles -> in_ready=0 two cycles, then rf_wdata=0xFFFF_FF80; lhu offset 2 -> 0x0000_80FF.
- beq: branch=1, alu_zero=1, cond_zero=1, pc_branch=0x100 -> redirect_valid=1, redirect_pc=0x100; cond_zero=0 -> no redirect, jal writes pc+4.
- MEM_TIMEOUT=4, load, no mem_rvalid -> mem_err=1 in 4th wait cycle, no rf_we, EMPTY next, late rvalid ignored.
- flush while WAIT_MEM and mem_rvalid same cycle -> all outputs 0, EMPTY next; back-to-back ALU stream at in_valid=1 -> one wb_valid per cycle.
- rst asserted mid-WAIT_MEM -> outputs 0 immediately, in_ready=1 after release.
